// File: rtl/seg_scan_mux.sv
// Four-digit multiplexed scan driver for a common-anode 7-segment display.
// Latches a packed BCD word, swaps it in only at frame boundaries, and scans one digit per slot.
module seg_scan_mux #(
    parameter int SCAN_DIV = 12000,
    parameter int DEAD_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] din,
    input  logic [3:0]  dp_en,
    input  logic        lzb,
    output logic [3:0]  bcd_out,
    output logic [3:0]  dig_n,
    output logic        dp_n,
    output logic        busy,
    output logic        frame
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_END = CNT_W'(DEAD_CYC);

    localparam logic [0:0] ST_DEAD  = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;
    // Phase every slot starts in; without a dead window the slot opens in SHOW.
    localparam logic [0:0] ST_FIRST = (DEAD_CYC == 0) ? ST_SHOW : ST_DEAD;

    function automatic logic [3:0] nibble_sel(input logic [15:0] word, input logic [1:0] sel);
        logic [3:0] nib;
        case (sel)
            2'd0:    nib = word[3:0];
            2'd1:    nib = word[7:4];
            2'd2:    nib = word[11:8];
            2'd3:    nib = word[15:12];
            default: nib = 4'hF;
        endcase
        return nib;
    endfunction

    // A digit is a leading zero when it and every digit to its left are zero.
    function automatic logic lz_blank(input logic [15:0] word, input logic [1:0] sel);
        logic blank;
        case (sel)
            2'd3:    blank = (word[15:12] == 4'd0);
            2'd2:    blank = (word[15:8] == 8'd0);
            2'd1:    blank = (word[15:4] == 12'd0);
            default: blank = 1'b0;
        endcase
        return blank;
    endfunction

    logic [CNT_W-1:0] div_cnt_r;
    logic [1:0]       slot_r;
    logic [0:0]       state_r;
    logic [15:0]      pend_din_r;
    logic [3:0]       pend_dp_r;
    logic [15:0]      disp_din_r;
    logic [3:0]       disp_dp_r;
    logic             disp_valid_r;

    logic             wrap_s;
    logic             fb_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [0:0]       state_nxt_s;
    logic [3:0]       bcd_nxt_s;
    logic [3:0]       dig_nxt_s;
    logic             dp_nxt_s;

    assign wrap_s = (div_cnt_r == CNT_LAST);
    assign fb_s   = wrap_s && (slot_r == 2'd3);

    // Next divider value and the phase it belongs to.
    always_comb begin
        cnt_nxt_s   = div_cnt_r + CNT_W'(1);
        state_nxt_s = state_r;
        if (wrap_s) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
            cnt_nxt_s = div_cnt_r + CNT_W'(1);
        end
        case (state_r)
            ST_DEAD: begin
                if (cnt_nxt_s == DEAD_END) begin
                    state_nxt_s = ST_SHOW;
                end else begin
                    state_nxt_s = ST_DEAD;
                end
            end
            ST_SHOW: begin
                if (cnt_nxt_s == {CNT_W{1'b0}}) begin
                    state_nxt_s = ST_FIRST;
                end else begin
                    state_nxt_s = ST_SHOW;
                end
            end
            default: state_nxt_s = ST_FIRST;
        endcase
    end

    // Slot divider, slot index and dead/show phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r <= {CNT_W{1'b0}};
            slot_r    <= 2'd0;
            state_r   <= ST_FIRST;
        end else begin
            div_cnt_r <= cnt_nxt_s;
            state_r   <= state_nxt_s;
            if (wrap_s) begin
                slot_r <= slot_r + 2'd1;
            end else begin
                slot_r <= slot_r;
            end
        end
    end

    // Load capture; the display word only changes on a frame boundary so a frame never tears.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_din_r   <= 16'h0000;
            pend_dp_r    <= 4'h0;
            disp_din_r   <= 16'h0000;
            disp_dp_r    <= 4'h0;
            disp_valid_r <= 1'b0;
            busy         <= 1'b0;
        end else if (load && fb_s) begin
            disp_din_r   <= din;
            disp_dp_r    <= dp_en;
            disp_valid_r <= 1'b1;
            busy         <= 1'b0;
        end else if (load) begin
            pend_din_r <= din;
            pend_dp_r  <= dp_en;
            busy       <= 1'b1;
        end else if (fb_s && busy) begin
            disp_din_r   <= pend_din_r;
            disp_dp_r    <= pend_dp_r;
            disp_valid_r <= 1'b1;
            busy         <= 1'b0;
        end else begin
            busy <= busy;
        end
    end

    // Digit drive for the current slot; a leading-zero digit stays enabled but shows blank.
    always_comb begin
        bcd_nxt_s = 4'hF;
        dig_nxt_s = 4'hF;
        dp_nxt_s  = 1'b1;
        if ((state_r == ST_SHOW) && disp_valid_r) begin
            dig_nxt_s = ~(4'b0001 << slot_r);
            dp_nxt_s  = ~disp_dp_r[slot_r];
            if (lzb && lz_blank(disp_din_r, slot_r)) begin
                bcd_nxt_s = 4'hF;
            end else begin
                bcd_nxt_s = nibble_sel(disp_din_r, slot_r);
            end
        end else begin
            bcd_nxt_s = 4'hF;
            dig_nxt_s = 4'hF;
            dp_nxt_s  = 1'b1;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_out <= 4'hF;
            dig_n   <= 4'hF;
            dp_n    <= 1'b1;
            frame   <= 1'b0;
        end else begin
            bcd_out <= bcd_nxt_s;
            dig_n   <= dig_nxt_s;
            dp_n    <= dp_nxt_s;
            frame   <= fb_s;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: two instances (8/2 and 2/0 slot timing) share stimulus and are
// compared each cycle against a cycle-count based reference model.
module tb_seg_scan_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, load, lzb;
    logic [15:0] din;
    logic [3:0]  dp_en;

    logic [3:0] a_bcd, a_dig_n, b_bcd, b_dig_n;
    logic       a_dp_n, a_busy, a_frame, b_dp_n, b_busy, b_frame;

    seg_scan_mux #(.SCAN_DIV(8), .DEAD_CYC(2)) dut_a (
        .clk(clk), .rst(rst), .load(load), .din(din), .dp_en(dp_en), .lzb(lzb),
        .bcd_out(a_bcd), .dig_n(a_dig_n), .dp_n(a_dp_n), .busy(a_busy), .frame(a_frame)
    );

    seg_scan_mux #(.SCAN_DIV(2), .DEAD_CYC(0)) dut_b (
        .clk(clk), .rst(rst), .load(load), .din(din), .dp_en(dp_en), .lzb(lzb),
        .bcd_out(b_bcd), .dig_n(b_dig_n), .dp_n(b_dp_n), .busy(b_busy), .frame(b_frame)
    );

    localparam logic [10:0] RST_V = {4'hF, 4'hF, 1'b1, 1'b0, 1'b0};

    logic [1:0][10:0] obs;
    logic [1:0][10:0] exp_o;
    assign obs[0] = {a_bcd, a_dig_n, a_dp_n, a_busy, a_frame};
    assign obs[1] = {b_bcd, b_dig_n, b_dp_n, b_busy, b_frame};

    int tests = 0;
    int fails = 0;

    // Reference model state: t is the cycle position inside the frame.
    int          t_m   [2];
    int          sd_m  [2];
    int          dc_m  [2];
    logic [15:0] disp_m[2];
    logic [15:0] pend_m[2];
    logic [3:0]  ddp_m [2];
    logic [3:0]  pdp_m [2];
    logic        valid_m[2];
    logic        busy_m [2];

    task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] p);
        int dv, sl;
        logic fb, dpn;
        logic [3:0] bc, dn;
        logic [15:0] hi;
        load = ld; din = d; dp_en = p;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                t_m[k] = 0; disp_m[k] = 16'h0; pend_m[k] = 16'h0; ddp_m[k] = 4'h0;
                pdp_m[k] = 4'h0; valid_m[k] = 1'b0; busy_m[k] = 1'b0;
                exp_o[k] = RST_V;
            end else begin
                dv = t_m[k] % sd_m[k];
                sl = (t_m[k] / sd_m[k]) % 4;
                fb = (dv == sd_m[k] - 1) && (sl == 3);
                bc = 4'hF; dn = 4'hF; dpn = 1'b1;
                if (dv >= dc_m[k] && valid_m[k]) begin
                    hi = disp_m[k] >> (4 * sl);
                    dn[sl] = 1'b0;
                    bc = (lzb && sl != 0 && hi == 16'h0) ? 4'hF : hi[3:0];
                    dpn = ~ddp_m[k][sl];
                end
                if (ld && fb) begin
                    disp_m[k] = d; ddp_m[k] = p; valid_m[k] = 1'b1; busy_m[k] = 1'b0;
                end else if (ld) begin
                    pend_m[k] = d; pdp_m[k] = p; busy_m[k] = 1'b1;
                end else if (fb && busy_m[k]) begin
                    disp_m[k] = pend_m[k]; ddp_m[k] = pdp_m[k]; valid_m[k] = 1'b1; busy_m[k] = 1'b0;
                end
                exp_o[k] = {bc, dn, dpn, busy_m[k], fb};
                t_m[k] = (t_m[k] + 1) % (4 * sd_m[k]);
            end
        end
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic align(input int phase);
        for (int n = 0; n < 64 && t_m[0] != phase; n++) step(1'b0, 16'h0, 4'h0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step(1'b0, 16'h0, 4'h0);
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (obs[k] !== RST_V) begin
                    fails++;
                    $display("FAIL reset dut%0d: got %h want %h", k, obs[k], RST_V);
                end
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_blank_startup();
        for (int n = 1; n <= 64; n++) begin
            step(1'b0, 16'h0, 4'h0);
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (obs[k] !== exp_o[k]) begin
                    fails++;
                    $display("FAIL blank_model dut%0d cyc %0d: got %h want %h", k, n, obs[k], exp_o[k]);
                end
            end
            tests++;
            if ({a_dig_n, a_bcd, a_frame, b_frame} !== {8'hFF, (n == 32 || n == 64), (n % 8 == 0)}) begin
                fails++;
                $display("FAIL blank_startup cyc %0d: got dig=%b bcd=%h fa=%b fb=%b want dig=1111 bcd=f fa=%b fb=%b",
                         n, a_dig_n, a_bcd, a_frame, b_frame, (n == 32 || n == 64), (n % 8 == 0));
            end
        end
    endtask

    task automatic test_scan_order();
        logic [3:0] bcd_t[4], dig_t[4];
        logic       dp_t[4];
        logic [8:0] e;
        int dv, sl;
        bcd_t[0] = 4'h4; bcd_t[1] = 4'h3; bcd_t[2] = 4'h2; bcd_t[3] = 4'h1;
        dig_t[0] = 4'b1110; dig_t[1] = 4'b1101; dig_t[2] = 4'b1011; dig_t[3] = 4'b0111;
        dp_t[0] = 1'b1; dp_t[1] = 1'b0; dp_t[2] = 1'b1; dp_t[3] = 1'b1;
        align(0);
        step(1'b1, 16'h1234, 4'b0010);
        tests++;
        if (a_busy !== 1'b1) begin fails++; $display("FAIL scan_busy_set: got %b want 1", a_busy); end
        for (int n = 0; n < 31; n++) begin
            step(1'b0, 16'h0, 4'h0);
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (obs[k] !== exp_o[k]) begin
                    fails++;
                    $display("FAIL scan_wait dut%0d: got %h want %h", k, obs[k], exp_o[k]);
                end
            end
        end
        tests++;
        if ({a_busy, a_frame} !== 2'b01) begin fails++; $display("FAIL scan_busy_clear: got busy=%b frame=%b want 0 1", a_busy, a_frame); end
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 16'h0, 4'h0);
            dv = i % 8; sl = i / 8;
            e = (dv < 2) ? {4'hF, 4'hF, 1'b1} : {bcd_t[sl], dig_t[sl], dp_t[sl]};
            tests++;
            if ({a_bcd, a_dig_n, a_dp_n} !== e) begin
                fails++;
                $display("FAIL scan_order cyc %0d: got %h want %h", i, {a_bcd, a_dig_n, a_dp_n}, e);
            end
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (obs[k] !== exp_o[k]) begin
                    fails++;
                    $display("FAIL scan_model dut%0d: got %h want %h", k, obs[k], exp_o[k]);
                end
            end
        end
    endtask

    task automatic test_lzb();
        logic [3:0] on_t[4], off_t[4], e;
        on_t[0] = 4'h0; on_t[1] = 4'h5; on_t[2] = 4'hF; on_t[3] = 4'hF;
        off_t[0] = 4'h0; off_t[1] = 4'h5; off_t[2] = 4'h0; off_t[3] = 4'h0;
        lzb = 1'b1;
        align(0);
        step(1'b1, 16'h0050, 4'b0000);
        for (int n = 0; n < 31; n++) step(1'b0, 16'h0, 4'h0);
        for (int f = 0; f < 2; f++) begin
            if (f == 1) lzb = 1'b0;
            for (int i = 0; i < 32; i++) begin
                step(1'b0, 16'h0, 4'h0);
                if (i % 8 >= 2) begin
                    e = (f == 0) ? on_t[i / 8] : off_t[i / 8];
                    tests++;
                    if (a_bcd !== e || a_dig_n === 4'hF) begin
                        fails++;
                        $display("FAIL lzb%0d slot %0d: got bcd=%h dig=%b want bcd=%h", 1 - f, i / 8, a_bcd, a_dig_n, e);
                    end
                end
                for (int k = 0; k < 2; k++) begin
                    tests++;
                    if (obs[k] !== exp_o[k]) begin
                        fails++;
                        $display("FAIL lzb_model dut%0d: got %h want %h", k, obs[k], exp_o[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        align(5);
        step(1'b1, 16'h1111, 4'b0001);
        step(1'b0, 16'h0, 4'h0);
        step(1'b1, 16'h2222, 4'b0100);
        tests++;
        if (a_busy !== 1'b1) begin fails++; $display("FAIL overwrite_busy: got %b want 1", a_busy); end
        for (int n = 0; n < 64 && t_m[0] != 0; n++) begin
            step(1'b0, 16'h0, 4'h0);
            tests++;
            if (obs[0] !== exp_o[0]) begin fails++; $display("FAIL overwrite_model: got %h want %h", obs[0], exp_o[0]); end
        end
        tests++;
        if (a_busy !== 1'b0) begin fails++; $display("FAIL overwrite_busy_clear: got %b want 0", a_busy); end
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 16'h0, 4'h0);
            if (i % 8 >= 2) begin
                tests++;
                if (a_bcd !== 4'h2) begin fails++; $display("FAIL overwrite_show cyc %0d: got %h want 2", i, a_bcd); end
            end
        end
        align(31);
        step(1'b1, 16'h9999, 4'h0);
        tests++;
        if ({a_busy, a_frame} !== 2'b01) begin fails++; $display("FAIL fb_load: got busy=%b frame=%b want 0 1", a_busy, a_frame); end
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 16'h0, 4'h0);
            if (i % 8 >= 2) begin
                tests++;
                if ({a_bcd, a_busy} !== {4'h9, 1'b0}) begin
                    fails++;
                    $display("FAIL fb_load_show cyc %0d: got bcd=%h busy=%b want 9 0", i, a_bcd, a_busy);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        align(0);
        step(1'b1, 16'h5678, 4'hF);
        align(20);
        tests++;
        if ({a_dig_n, a_busy} !== {4'b1011, 1'b1}) begin
            fails++;
            $display("FAIL mid_reset_pre: got dig=%b busy=%b want 1011 1", a_dig_n, a_busy);
        end
        rst = 1'b1;
        step(1'b0, 16'h0, 4'h0);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (obs[k] !== RST_V) begin fails++; $display("FAIL mid_reset dut%0d: got %h want %h", k, obs[k], RST_V); end
        end
        for (int n = 0; n < 64; n++) begin
            step(1'b0, 16'h0, 4'h0);
            tests++;
            if ({a_dig_n, a_bcd, b_dig_n, b_bcd} !== 16'hFFFF || obs !== exp_o) begin
                fails++;
                $display("FAIL mid_reset_blank cyc %0d: got %h want %h", n, obs, exp_o);
            end
        end
    endtask

    task automatic test_dead0();
        logic [3:0] nib_t[4], m;
        nib_t[0] = 4'h1; nib_t[1] = 4'h2; nib_t[2] = 4'h3; nib_t[3] = 4'h4;
        rst = 1'b1;
        step(1'b0, 16'h0, 4'h0);
        rst = 1'b0;
        step(1'b1, 16'h4321, 4'b0101);
        for (int n = 0; n < 7; n++) step(1'b0, 16'h0, 4'h0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 16'h0, 4'h0);
            m = 4'b0001 << ((i / 2) % 4);
            tests++;
            if ({b_dig_n, b_bcd, b_frame} !== {~m, nib_t[(i / 2) % 4], (i % 8 == 7)}) begin
                fails++;
                $display("FAIL dead0 cyc %0d: got dig=%b bcd=%h frame=%b want dig=%b bcd=%h frame=%b",
                         i, b_dig_n, b_bcd, b_frame, ~m, nib_t[(i / 2) % 4], (i % 8 == 7));
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] d;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 49) == 0) lzb = ~lzb;
            rst = ($urandom_range(0, 499) == 0);
            for (int j = 0; j < 4; j++) d[4 * j +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            step(($urandom_range(0, 9) == 0), d, 4'($urandom_range(0, 15)));
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (obs[k] !== exp_o[k]) begin
                    fails++;
                    $display("FAIL random dut%0d cyc %0d: got %h want %h", k, n, obs[k], exp_o[k]);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        sd_m[0] = 8; dc_m[0] = 2;
        sd_m[1] = 2; dc_m[1] = 0;
        rst = 1'b1; load = 1'b0; lzb = 1'b0; din = 16'h0; dp_en = 4'h0;
        test_reset();
        test_blank_startup();
        test_scan_order();
        test_lzb();
        test_back_to_back();
        test_mid_reset();
        test_dead0();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
